uart_frame_gen: RTL and testbench

Parametrised RS232 stimulus source. It replaces the free-running random RXD toggler with correctly framed asynchronous serial frames: start bit, data bits, optional parity, then stop bits. Payload comes either from a valid/ready byte stream or from an internal LFSR. It drives RS232_DCE_RXD of the scoreboard top in simulation and can also serve as a synthesizable on-board loopback source.

---
 rtl/uart_frame_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 23 ++
 rtl/uart_frame_gen.sv | 145 ++++++++++++++
 tb/tb_uart_frame_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame generator (and a future receiver).
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_GAP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int frame_bits(input int dw, input int par, input int stop, input int gap);
    return 1 + dw + ((par != PAR_NONE) ? 1 : 0) + stop + gap;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time down-counter: holds at DIV-1 while restarted, then ticks once every DIV cycles.
module uart_baud_tick #(
  parameter int DIV = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [15:0] LOAD = 16'(DIV - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         r_cnt <= LOAD;
    else if (i_restart || r_cnt == 16'd0) r_cnt <= LOAD;
    else                                  r_cnt <= r_cnt - 16'd1;
  end

  assign o_tick = (r_cnt == 16'd0) & ~i_restart;

endmodule

// File: rtl/uart_frame_gen.sv
// Framed async-serial stimulus source: start, data LSB first, optional parity, stop, gap.
// Optional stop-bit error injection under `UART_FRAME_GEN_ERR_INJ_EN.
module uart_frame_gen
  import uart_frame_pkg::*;
#(
  parameter int          CLK_DIV   = 434,
  parameter int          DATA_W    = 8,
  parameter int          PARITY    = 0,
  parameter int          STOP_BITS = 1,
  parameter int          GAP_BITS  = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              CLK_50MHZ,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              MODE,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
`ifdef UART_FRAME_GEN_ERR_INJ_EN
  input  logic              INJ_ERR,
`endif
  output logic              DATA_READY,
  output logic              TXD,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [15:0]       FRAME_CNT
);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_bcnt, w_bcnt_nxt;
  logic [DATA_W-1:0] r_data, w_data_sh;
  logic [15:0]       r_lfsr;
  logic [15:0]       r_frame_cnt;
  logic              r_txd, w_txd_nxt;
  logic              w_tick, w_load, w_par, w_last_stop, w_done, w_inj;

  uart_baud_tick #(.DIV(CLK_DIV)) u_baud (
    .i_clk     (CLK_50MHZ),
    .i_rst_n   (RST_N),
    .i_restart (r_state == ST_IDLE),
    .o_tick    (w_tick)
  );

  // Payload and mode are only looked at here, so mid-frame changes cannot leak in.
  assign w_load      = (r_state == ST_IDLE) & EN & (MODE | DATA_VALID);
  assign w_par       = (^r_data) ^ (PARITY == PAR_ODD);
  assign w_last_stop = (r_bcnt == 4'(STOP_BITS - 1));
  assign w_data_sh   = r_data >> w_bcnt_nxt;

`ifdef UART_FRAME_GEN_ERR_INJ_EN
  logic r_inj;
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N)      r_inj <= 1'b0;
    else if (w_load) r_inj <= INJ_ERR;
  end
  assign w_inj = r_inj;
`else
  assign w_inj = 1'b0;
`endif

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_bcnt      <= 4'd0;
      r_data      <= '0;
      r_lfsr      <= LFSR_SEED;
      r_txd       <= 1'b1;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_txd   <= w_txd_nxt;
      if (w_load)        r_data      <= MODE ? r_lfsr[DATA_W-1:0] : DATA_IN;
      if (w_load & MODE) r_lfsr      <= lfsr_step(r_lfsr);
      if (w_done)        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // r_bcnt indexes data bits, stop bits and gap bits in turn.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      ST_IDLE:  if (w_load) begin
                  w_state_nxt = ST_START;
                  w_bcnt_nxt  = 4'd0;
                end
      ST_START: if (w_tick) begin
                  w_state_nxt = ST_DATA;
                  w_bcnt_nxt  = 4'd0;
                end
      ST_DATA:  if (w_tick) begin
                  if (r_bcnt == 4'(DATA_W - 1)) begin
                    w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    w_bcnt_nxt  = 4'd0;
                  end else begin
                    w_bcnt_nxt  = r_bcnt + 4'd1;
                  end
                end
      ST_PAR:   if (w_tick) begin
                  w_state_nxt = ST_STOP;
                  w_bcnt_nxt  = 4'd0;
                end
      ST_STOP:  if (w_tick) begin
                  if (w_last_stop) begin
                    w_state_nxt = (GAP_BITS != 0) ? ST_GAP : ST_IDLE;
                    w_bcnt_nxt  = 4'd0;
                  end else begin
                    w_bcnt_nxt  = r_bcnt + 4'd1;
                  end
                end
      ST_GAP:   if (w_tick) begin
                  if (r_bcnt == 4'(GAP_BITS - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_bcnt_nxt  = 4'd0;
                  end else begin
                    w_bcnt_nxt  = r_bcnt + 4'd1;
                  end
                end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bcnt_nxt  = 4'd0;
      end
    endcase
  end

  // Line level is computed from the next state so TXD can be a plain flop.
  always_comb begin
    DATA_READY = RST_N & (r_state == ST_IDLE) & EN & ~MODE;
    BUSY       = (r_state != ST_IDLE);
    w_done     = (r_state == ST_STOP) & w_tick & w_last_stop;
    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_data_sh[0];
      ST_PAR:   w_txd_nxt = w_par;
      ST_STOP:  w_txd_nxt = ~(w_inj & (w_bcnt_nxt == 4'd0));
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  assign TXD        = r_txd;
  assign FRAME_DONE = w_done;
  assign FRAME_CNT  = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_gen.sv
// Scoreboard bench for uart_frame_gen: three instances (no/even/odd parity), CLK_DIV=4.
module tb_uart_frame_gen;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, mode = 1'b0, valid = 1'b0;
  logic [7:0]  din = 8'h00;
`ifdef UART_FRAME_GEN_ERR_INJ_EN
  logic        inj = 1'b0;
`endif
  logic        rdy [3];
  logic        txd [3];
  logic        busy[3];
  logic        done[3];
  logic [15:0] fcnt[3];

  int          n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] smp_txd, smp_done, smp_busy;
  int          t_start;
  bit          cap_to;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_frame_gen #(
      .CLK_DIV(DIV), .DATA_W(8), .PARITY(g), .STOP_BITS(1), .GAP_BITS(1), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .CLK_50MHZ (clk),
      .RST_N     (rst_n),
      .EN        (en),
      .MODE      (mode),
      .DATA_IN   (din),
      .DATA_VALID(valid),
`ifdef UART_FRAME_GEN_ERR_INJ_EN
      .INJ_ERR   (inj),
`endif
      .DATA_READY(rdy[g]),
      .TXD       (txd[g]),
      .BUSY      (busy[g]),
      .FRAME_DONE(done[g]),
      .FRAME_CNT (fcnt[g])
    );
  end

  // Reference line level for bit position pos (0 = start) of a frame carrying d.
  function automatic logic exp_lvl(input logic [7:0] d, input int pm, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (pos == 9 && pm == 1) return ^d;
    if (pos == 9 && pm == 2) return ~^d;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    en = 1'b1; mode = 1'b0; din = d; valid = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Waits (bounded) for a start bit on instance k, then records ncyc cycles of outputs.
  task automatic capture(input int k, input int ncyc);
    int n = 0;
    cap_to = 1'b0;
    smp_txd = '1; smp_done = '0; smp_busy = '0;
    while (txd[k] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (txd[k] !== 1'b0) begin cap_to = 1'b1; return; end
    t_start = cyc;
    for (int j = 0; j < ncyc; j++) begin
      smp_txd[j] = txd[k]; smp_done[j] = done[k]; smp_busy[j] = busy[k];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    en = 1'b1;
    #1;
    n_tests++; if (txd[0] !== 1'b1)   begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd[0]); end
    n_tests++; if (busy[0] !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    n_tests++; if (rdy[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy[0]); end
    n_tests++; if (done[0] !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done[0]); end
    n_tests++; if (fcnt[0] !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", fcnt[0]); end
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] e;
    en = 1'b1; mode = 1'b0;
    #1;
    n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL mode0_ready: got %b want 1", rdy[0]); end
    send(8'h55);
    en = 1'b0;
    capture(0, 44);
    n_tests++;
    if (cap_to) begin n_fail++; $display("FAIL mode0_start: got no start bit want start"); end
    else begin
      e = exp_q.pop_front();
      for (int b = 0; b < 10; b++) begin
        n_tests++;
        if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, 0, b)}}) begin
          n_fail++; $display("FAIL mode0_bit%0d: got %b want %b x4", b, smp_txd[4*b +: 4], exp_lvl(e, 0, b));
        end
      end
      n_tests++; if (smp_done[43:0] !== (44'd1 << 39)) begin n_fail++; $display("FAIL mode0_done: got %h want %h", smp_done[43:0], 44'd1 << 39); end
      n_tests++; if (smp_txd[43:40] !== 4'hF) begin n_fail++; $display("FAIL mode0_gap: got %b want 1111", smp_txd[43:40]); end
      n_tests++; if (smp_busy[20] !== 1'b1) begin n_fail++; $display("FAIL mode0_busy_mid: got %b want 1", smp_busy[20]); end
      n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL mode0_busy_end: got %b want 0", busy[0]); end
      n_tests++; if (fcnt[0] !== 16'd1) begin n_fail++; $display("FAIL mode0_cnt: got %0d want 1", fcnt[0]); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] e;
    for (int pm = 1; pm <= 2; pm++) begin
      do_reset();
      send(8'h07);
      en = 1'b0;
      capture(pm, 48);
      n_tests++;
      if (cap_to) begin n_fail++; $display("FAIL par%0d_start: got no start bit want start", pm); end
      else begin
        e = exp_q.pop_front();
        for (int b = 0; b < 11; b++) begin
          n_tests++;
          if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, pm, b)}}) begin
            n_fail++; $display("FAIL par%0d_bit%0d: got %b want %b x4", pm, b, smp_txd[4*b +: 4], exp_lvl(e, pm, b));
          end
        end
        n_tests++;
        if (smp_txd[38] !== ((pm == 1) ? 1'b1 : 1'b0)) begin
          n_fail++; $display("FAIL par%0d_value: got %b want %b", pm, smp_txd[38], (pm == 1) ? 1'b1 : 1'b0);
        end
        n_tests++; if (smp_done[47:0] !== (48'd1 << 43)) begin n_fail++; $display("FAIL par%0d_done: got %h want %h", pm, smp_done[47:0], 48'd1 << 43); end
        n_tests++; if (fcnt[pm] !== 16'd1) begin n_fail++; $display("FAIL par%0d_cnt: got %0d want 1", pm, fcnt[pm]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] lf;
    logic [7:0]  e;
    int          ts[3];
    do_reset();
    lf = 16'hACE1;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(lf[7:0]);
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    mode = 1'b1; en = 1'b1;
    #1;
    n_tests++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL lfsr_ready: got %b want 0", rdy[0]); end
    for (int f = 0; f < 3; f++) begin
      capture(0, 44);
      ts[f] = t_start;
      n_tests++;
      if (cap_to) begin n_fail++; $display("FAIL lfsr_f%0d_start: got no start bit want start", f); end
      else begin
        e = exp_q.pop_front();
        for (int b = 0; b < 10; b++) begin
          n_tests++;
          if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, 0, b)}}) begin
            n_fail++; $display("FAIL lfsr_f%0d_bit%0d: got %b want %b x4 (byte %h)", f, b, smp_txd[4*b +: 4], exp_lvl(e, 0, b), e);
          end
        end
      end
    end
    en = 1'b0;
    n_tests++; if (ts[1] - ts[0] !== 45) begin n_fail++; $display("FAIL lfsr_spacing01: got %0d want 45", ts[1] - ts[0]); end
    n_tests++; if (ts[2] - ts[1] !== 45) begin n_fail++; $display("FAIL lfsr_spacing12: got %0d want 45", ts[2] - ts[1]); end
    n_tests++; if (fcnt[0] !== 16'd3) begin n_fail++; $display("FAIL lfsr_cnt: got %0d want 3", fcnt[0]); end
  endtask

  task automatic test_en_drop();
    logic [7:0] e;
    bit         quiet = 1'b1;
    do_reset();
    en = 1'b1; mode = 1'b0; din = 8'hA3; valid = 1'b1;
    exp_q.push_back(8'hA3);
    @(negedge clk);
    din = 8'hFF;
    fork
      capture(0, 44);
      begin repeat (17) @(negedge clk); en = 1'b0; end
    join
    n_tests++;
    if (cap_to) begin n_fail++; $display("FAIL endrop_start: got no start bit want start"); end
    else begin
      e = exp_q.pop_front();
      for (int b = 0; b < 10; b++) begin
        n_tests++;
        if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, 0, b)}}) begin
          n_fail++; $display("FAIL endrop_bit%0d: got %b want %b x4", b, smp_txd[4*b +: 4], exp_lvl(e, 0, b));
        end
      end
      n_tests++; if (fcnt[0] !== 16'd1) begin n_fail++; $display("FAIL endrop_cnt: got %0d want 1", fcnt[0]); end
      for (int j = 0; j < 20; j++) begin
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0) quiet = 1'b0;
        @(negedge clk);
      end
      n_tests++; if (!quiet) begin n_fail++; $display("FAIL endrop_idle: got activity want idle line"); end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    do_reset();
    send(8'h5A);
    en = 1'b0;
    capture(0, 44);
    void'(exp_q.pop_front());
    n_tests++; if (fcnt[0] !== 16'd1) begin n_fail++; $display("FAIL rstmid_pre_cnt: got %0d want 1", fcnt[0]); end
    send(8'h3C);
    en = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++; if (txd[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre_txd: got %b want 0", txd[0]); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (txd[0] !== 1'b1)   begin n_fail++; $display("FAIL rstmid_txd: got %b want 1", txd[0]); end
    n_tests++; if (busy[0] !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy[0]); end
    n_tests++; if (fcnt[0] !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", fcnt[0]); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h96);
    en = 1'b0;
    capture(0, 44);
    n_tests++;
    if (cap_to) begin n_fail++; $display("FAIL rstmid_start: got no start bit want start"); end
    else begin
      e = exp_q.pop_front();
      for (int b = 0; b < 10; b++) begin
        n_tests++;
        if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, 0, b)}}) begin
          n_fail++; $display("FAIL rstmid_bit%0d: got %b want %b x4", b, smp_txd[4*b +: 4], exp_lvl(e, 0, b));
        end
      end
      n_tests++; if (fcnt[0] !== 16'd1) begin n_fail++; $display("FAIL rstmid_post_cnt: got %0d want 1", fcnt[0]); end
    end
  endtask

`ifdef UART_FRAME_GEN_ERR_INJ_EN
  task automatic test_err_inj();
    logic [7:0] e;
    do_reset();
    inj = 1'b1;
    send(8'hA5);
    inj = 1'b0; en = 1'b0;
    capture(0, 44);
    n_tests++;
    if (cap_to) begin n_fail++; $display("FAIL inj_start: got no start bit want start"); end
    else begin
      e = exp_q.pop_front();
      for (int b = 0; b < 9; b++) begin
        n_tests++;
        if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, 0, b)}}) begin
          n_fail++; $display("FAIL inj_bit%0d: got %b want %b x4", b, smp_txd[4*b +: 4], exp_lvl(e, 0, b));
        end
      end
      n_tests++; if (smp_txd[39:36] !== 4'h0) begin n_fail++; $display("FAIL inj_stop: got %b want 0000", smp_txd[39:36]); end
      n_tests++; if (smp_done[43:0] !== (44'd1 << 39)) begin n_fail++; $display("FAIL inj_done: got %h want %h", smp_done[43:0], 44'd1 << 39); end
      n_tests++; if (fcnt[0] !== 16'd1) begin n_fail++; $display("FAIL inj_cnt: got %0d want 1", fcnt[0]); end
    end
    send(8'h5A);
    en = 1'b0;
    capture(0, 44);
    n_tests++;
    if (cap_to) begin n_fail++; $display("FAIL inj_next_start: got no start bit want start"); end
    else begin
      e = exp_q.pop_front();
      for (int b = 0; b < 10; b++) begin
        n_tests++;
        if (smp_txd[4*b +: 4] !== {4{exp_lvl(e, 0, b)}}) begin
          n_fail++; $display("FAIL inj_next_bit%0d: got %b want %b x4", b, smp_txd[4*b +: 4], exp_lvl(e, 0, b));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_parity();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
`ifdef UART_FRAME_GEN_ERR_INJ_EN
    test_err_inj();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
